// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM state encoding, owner id and
// requester count. Imported by the interface users, the top and the picker.
// No ports; compile this file first.
package data_mem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RESP} state_t;

  // 0 = requester m0 (load/store unit), 1 = requester m1 (UART/debug loader)
  typedef logic owner_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data_memory port of the arbiter.
// Ports: m0_*/m1_* request/grant/read-return, mem_* memory drive, busy.
// slave = arbiter side, master = requesters plus memory (bench/system side).
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30
);
  logic                     m0_req;
  logic                     m0_we;
  logic [ADDRESS_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0]    m0_wdata;
  logic                     m0_gnt;
  logic                     m0_rvalid;
  logic [DATA_WIDTH-1:0]    m0_rdata;

  logic                     m1_req;
  logic                     m1_we;
  logic [ADDRESS_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0]    m1_wdata;
  logic                     m1_gnt;
  logic                     m1_rvalid;
  logic [DATA_WIDTH-1:0]    m1_rdata;

  logic                     mem_read_En;
  logic                     mem_write_En;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_data_in;
  logic [DATA_WIDTH-1:0]    mem_data_out;

  logic                     busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_read_En, mem_write_En, mem_address, mem_data_in,
    input  mem_data_out,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_read_En, mem_write_En, mem_address, mem_data_in,
    output mem_data_out,
    input  busy
  );

endinterface

// File: rtl/data_mem_arbiter_pick.sv
// dm_arb_pick: combinational winner select between the two requesters.
// Ports: req[1:0] in, rr_ptr in (last winner, only with ARB_ROUND_ROBIN_EN), winner out.
// Default build: fixed priority, m0 wins a tie. ARB_ROUND_ROBIN_EN: tie goes to non-last winner.
module dm_arb_pick
  import data_mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t             rr_ptr,
`endif
  input  logic [NUM_REQ-1:0] req,
  output owner_t             winner
);

  always_comb begin
    winner = 1'b0;
    if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = ~rr_ptr;
`else
      winner = 1'b0;
`endif
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: serialises m0 (LSU) and m1 (loader) onto single-port data_memory.
// Ports: clk, rstN (async active-low), bus (slave modport: m0_*, m1_*, mem_*, busy).
// Write occupies IDLE+ISSUE; read IDLE+ISSUE+RDATA+RESP. Optional ARB_ROUND_ROBIN_EN.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30
) (
  input  logic               clk,
  input  logic               rstN,
  data_mem_arbiter_if.slave  bus
);

  state_t                   state, state_d;
  owner_t                   owner;
  owner_t                   winner;
  logic                     we_q;
  logic                     take;
  logic [NUM_REQ-1:0]       req;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  assign req = {bus.m1_req, bus.m0_req};

`ifdef ARB_ROUND_ROBIN_EN
  owner_t rr_ptr;

  dm_arb_pick u_pick (
    .rr_ptr (rr_ptr),
    .req    (req),
    .winner (winner)
  );
`else
  dm_arb_pick u_pick (
    .req    (req),
    .winner (winner)
  );
`endif

  assign sel_we    = winner ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

  assign bus.busy = (state != IDLE);

  always_comb begin
    state_d = state;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = we_q ? IDLE : RDATA;
      RDATA:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so ISSUE-cycle values (enables, address, data,
  // grant) are loaded on the same edge that samples the request in IDLE.
  // mem_address/mem_data_in double as the latched address and write data.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state            <= IDLE;
      owner            <= 1'b0;
      we_q             <= 1'b0;
      bus.m0_gnt       <= 1'b0;
      bus.m1_gnt       <= 1'b0;
      bus.m0_rvalid    <= 1'b0;
      bus.m1_rvalid    <= 1'b0;
      bus.m0_rdata     <= '0;
      bus.m1_rdata     <= '0;
      bus.mem_read_En  <= 1'b0;
      bus.mem_write_En <= 1'b0;
      bus.mem_address  <= '0;
      bus.mem_data_in  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr           <= 1'b0;
`endif
    end else begin
      state            <= state_d;
      bus.m0_gnt       <= 1'b0;
      bus.m1_gnt       <= 1'b0;
      bus.m0_rvalid    <= 1'b0;
      bus.m1_rvalid    <= 1'b0;
      bus.mem_read_En  <= 1'b0;
      bus.mem_write_En <= 1'b0;
      if (take) begin
        owner            <= winner;
        we_q             <= sel_we;
        bus.mem_write_En <= sel_we;
        bus.mem_read_En  <= !sel_we;
        bus.mem_address  <= sel_addr;
        bus.mem_data_in  <= sel_wdata;
        bus.m0_gnt       <= !winner;
        bus.m1_gnt       <= winner;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr           <= winner;
`endif
      end
      // Memory output is valid during RDATA; capture it so rdata and rvalid
      // appear together in RESP.
      if (state == RDATA) begin
        if (owner) begin
          bus.m1_rdata  <= bus.mem_data_out;
          bus.m1_rvalid <= 1'b1;
        end else begin
          bus.m0_rdata  <= bus.mem_data_out;
          bus.m0_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port synchronous data_memory.
- Requester 0 is the processor load/store unit. Requester 1 is the UART/debug loader, which preloads data memory and dumps it after process_done.
- Serialises accesses and drives the memory's read_En/write_En/address/data_in.
- Returns read data against the memory's 1-cycle registered read latency.

Parameters:
- DATA_WIDTH, 32, data word width; matches data_memory.
- ADDRESS_WIDTH, 30, word address width; matches data_memory.

Ports:
- clk  input  1  system clock, rising edge
- rstN  input  1  asynchronous active-low reset
- m0_req  input  1  requester 0 access request; held until m0_gnt
- m0_we  input  1  1 = write, 0 = read; stable while m0_req=1
- m0_addr  input  ADDRESS_WIDTH  word address
- m0_wdata  input  DATA_WIDTH  write data
- m0_gnt  output  1  1-cycle pulse: request accepted
- m0_rvalid  output  1  1-cycle pulse: m0_rdata valid
- m0_rdata  output  DATA_WIDTH  read data, held until next m0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for requester 1
- mem_read_En  output  1  to data_memory read_En
- mem_write_En  output  1  to data_memory write_En
- mem_address  output  ADDRESS_WIDTH  to data_memory address
- mem_data_in  output  DATA_WIDTH  to data_memory data_in
- mem_data_out  input  DATA_WIDTH  from data_memory data_out
- busy  output  1  1 when state != IDLE

Behaviour:
- Reset: every output 0; state IDLE; owner register 0; RR pointer 0.
- All outputs are registered except busy, which decodes state.
- Reset asserted mid-operation:
  - state returns to IDLE and enables drop asynchronously;
  - no pending gnt or rvalid is emitted;
  - the requester must re-request.
- State IDLE:
  - any req sampled at the edge: pick winner; latch owner, we, addr, wdata; go ISSUE.
  - no req: stay in IDLE.
- State ISSUE, exactly 1 cycle:
  - mem_write_En=we or mem_read_En=!we; never both high.
  - mem_address and mem_data_in come from the latched values.
  - gnt[owner]=1 this cycle.
  - Next state: write -> IDLE; read -> RDATA.
- State RDATA, 1 cycle: mem_data_out is valid; capture it into the owner's rdata register; go RESP.
- State RESP, 1 cycle: rvalid[owner]=1; go IDLE.
- Occupancy, counted from the IDLE sampling edge:
  - write: 2 cycles;
  - read: 4 cycles, with rvalid in the 4th cycle.
- Requests are only sampled in IDLE; a req raised in any other state waits.
- Both gnt outputs are never high together. Both rvalid outputs are never high together.
- Requester protocol:
  - after gnt, deassert req or present a new request the next cycle;
  - a req dropped before gnt is silently ignored;
  - changing we/addr/wdata while waiting takes effect at the next IDLE sample.
- Priority (default): fixed, m0 wins a tie. m1 can be starved; this is acceptable because the loader only runs while the core is held off.
- rdata registers are not cleared between reads; only reset clears them.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - a 1-bit last-winner pointer updates at each ISSUE;
  - on a tie, the requester that did not win last time is granted;
  - a single requester is always granted;
  - the pointer resets to 0, so m1 wins the first tie.
- Undefined: fixed m0 priority as above; no pointer flop.

Decomposition:
- Package data_mem_arb_pkg:
  - typedef enum logic [1:0] state_t {IDLE, ISSUE, RDATA, RESP};
  - typedef logic owner_t (0 = m0, 1 = m1);
  - localparam NUM_REQ = 2.
- One sub-module, dm_arb_pick: combinational winner select from req[1:0] and the RR pointer. The ARB_ROUND_ROBIN_EN logic lives here.

Test Plan:
- Reset then m0 write, addr 0x10, data 0xDEADBEEF -> m0_gnt pulses 1 cycle later with mem_write_En=1, mem_address=0x10, mem_data_in=0xDEADBEEF; busy drops the next cycle.
- m0 read of addr 0x10 after that write -> mem_read_En in ISSUE; m0_rvalid in the 4th cycle with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Both req held, m0 read 0x4, m1 write 0x8 = 0x55 -> without macro: m0 granted first, m1 gnt after RESP; with ARB_ROUND_ROBIN_EN: m1 first, then m0, then alternate on repeated ties.
- rstN pulsed low during RDATA of an m1 read -> all outputs 0 immediately; no m1_rvalid ever appears; the next request is serviced normally.
- m1 back-to-back writes 0x0..0x3 with req held continuously -> exactly 4 gnt pulses 2 cycles apart; mem_write_En never coincides with mem_read_En.
- m0_req pulsed for 1 cycle while busy and dropped -> no m0_gnt; the arbiter returns to IDLE and idles.
